// File: rtl/s_memory_shuffle_param.sv
// RC4 key scheduler over a single-port S-memory: optional identity fill, then a 6-cycle read/read/write/write swap per entry.
// Latency N*(INIT_EN+6)+1 cycles from accept to finish; no backpressure, start is ignored while busy.
module s_memory_shuffle_param #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3,
    parameter bit INIT_EN   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [ADDR_W-1:0]      address,
    output logic [7:0]             data,
    output logic                   write_enable,
    output logic                   busy,
    output logic                   finish
);
    localparam int                KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_I = '1;
    localparam logic [KW-1:0]     LAST_K = KW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_W-1:0]      i, j;
    logic [KW-1:0]          kidx;
    logic [7:0]             si, sj;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [7:0]             key_byte;

    // Byte 0 sits in the most significant byte of the key.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KW'(k)) key_byte = key_r[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT_EN ? FILL : RD_I;
            FILL:    if (i == LAST_I) state_nxt = RD_I;
            RD_I:    state_nxt = CAP_I;
            CAP_I:   state_nxt = RD_J;
            RD_J:    state_nxt = CAP_J;
            CAP_J:   state_nxt = WR_I;
            WR_I:    state_nxt = WR_J;
            WR_J:    state_nxt = (i == LAST_I) ? DONE : RD_I;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so q and start never reach them combinationally.
    always_comb begin
        address      = '0;
        data         = '0;
        write_enable = 1'b0;
        case (state)
            FILL: begin
                address      = i;
                data         = 8'(i);
                write_enable = 1'b1;
            end
            RD_I: address = i;
            RD_J: address = j;
            WR_I: begin
                address      = i;
                data         = sj;
                write_enable = 1'b1;
            end
            WR_J: begin
                address      = j;
                data         = si;
                write_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE) && (state != DONE);
    assign finish = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            si    <= '0;
            sj    <= '0;
            key_r <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    key_r <= secret_key;
                    i     <= '0;
                    j     <= '0;
                    kidx  <= '0;
                end
                FILL: i <= i + 1'b1;
                CAP_I: begin
                    si <= q;
                    j  <= j + q[ADDR_W-1:0] + key_byte[ADDR_W-1:0];
                end
                CAP_J: sj <= q;
                WR_J: if (i != LAST_I) begin
                    i    <= i + 1'b1;
                    kidx <= (kidx == LAST_K) ? '0 : kidx + 1'b1;
                end
                DONE: begin
                    i <= '0;
                    j <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_s_memory_shuffle_param.sv
// Scoreboard bench: a software KSA predicts every RAM write and the final image for three parameterisations.
module tb_s_memory_shuffle_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, preload1;
    logic        start0, start1, start2;
    logic [23:0] key0, key1;
    logic [7:0]  key2;
    logic [7:0]  q0r, q1r, q2r, a0, a1, d0, d1, d2;
    logic [3:0]  a2;
    logic        we0, we1, we2, busy0, busy1, busy2, fin0, fin1, fin2;
    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [7:0]  mem2 [16];

    int tests = 0;
    int fails = 0;
    int sel   = 0;
    logic [15:0] sb0[$], sb1[$], sb2[$], mq[$];
    int mimg [256];
    int imga [256];
    logic fin_s, busy_s, we_s;

    s_memory_shuffle_param u0 (
        .clk(clk), .reset(rst_n), .start(start0), .secret_key(key0), .q(q0r),
        .address(a0), .data(d0), .write_enable(we0), .busy(busy0), .finish(fin0));
    s_memory_shuffle_param #(.INIT_EN(1'b0)) u1 (
        .clk(clk), .reset(rst_n), .start(start1), .secret_key(key1), .q(q1r),
        .address(a1), .data(d1), .write_enable(we1), .busy(busy1), .finish(fin1));
    s_memory_shuffle_param #(.ADDR_W(4), .KEY_BYTES(1)) u2 (
        .clk(clk), .reset(rst_n), .start(start2), .secret_key(key2), .q(q2r),
        .address(a2), .data(d2), .write_enable(we2), .busy(busy2), .finish(fin2));

    always @(posedge clk) begin
        if (we0) mem0[a0] <= d0;
        q0r <= mem0[a0];
    end
    always @(posedge clk) begin
        if (preload1) begin
            for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
        end else if (we1) mem1[a1] <= d1;
        q1r <= mem1[a1];
    end
    always @(posedge clk) begin
        if (we2) mem2[a2] <= d2;
        q2r <= mem2[a2];
    end

    assign fin_s  = (sel == 0) ? fin0  : (sel == 1) ? fin1  : fin2;
    assign busy_s = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    assign we_s   = (sel == 0) ? we0   : (sel == 1) ? we1   : we2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Plain KSA over an int array; records the write stream the engine must produce.
    task automatic model(input int n, input int kb, input logic [127:0] key, input bit init);
        int s [256];
        int j, kbyte, tmp;
        mq.delete();
        for (int x = 0; x < n; x++) begin
            s[x] = x;
            if (init) mq.push_back({8'(x), 8'(x)});
        end
        j = 0;
        for (int x = 0; x < n; x++) begin
            kbyte = int'((key >> (8 * (kb - 1 - (x % kb)))) & 128'hff);
            j = (j + s[x] + kbyte) % n;
            mq.push_back({8'(x), 8'(s[j])});
            mq.push_back({8'(j), 8'(s[x])});
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        for (int x = 0; x < 256; x++) mimg[x] = (x < n) ? s[x] : 0;
    endtask

    always @(negedge clk) begin : mon0
        logic [15:0] e;
        if (rst_n && we0) begin
            if (sb0.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr0: got unexpected write %0h<=%0h, required no write", a0, d0);
            end else begin
                e = sb0.pop_front();
                chk("wr0", {16'h0, a0, d0}, {16'h0, e});
            end
        end
    end
    always @(negedge clk) begin : mon1
        logic [15:0] e;
        if (rst_n && we1) begin
            if (sb1.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr1: got unexpected write %0h<=%0h, required no write", a1, d1);
            end else begin
                e = sb1.pop_front();
                chk("wr1", {16'h0, a1, d1}, {16'h0, e});
            end
        end
    end
    always @(negedge clk) begin : mon2
        logic [15:0] e;
        if (rst_n && we2) begin
            if (sb2.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr2: got unexpected write %0h<=%0h, required no write", a2, d2);
            end else begin
                e = sb2.pop_front();
                chk("wr2", {20'h0, a2, d2}, {16'h0, e});
            end
        end
    end

    // Entered #1 after the accepting edge (cycle 1); finish must be high in cycle expc.
    task automatic run_to_finish(input int expc, input string nm, input bit chk_we1);
        int cyc;
        cyc = 1;
        chk({nm, "_busy_rise"}, 32'(busy_s), 1);
        if (chk_we1) chk({nm, "_no_we_c1"}, 32'(we_s), 0);
        while (fin_s !== 1'b1 && cyc < expc + 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, expc);
        chk({nm, "_finish"}, 32'(fin_s), 1);
        chk({nm, "_busy_at_fin"}, 32'(busy_s), 0);
        @(posedge clk); #1;
        chk({nm, "_fin_pulse"}, 32'(fin_s), 0);
    endtask

    task automatic check_image(input string nm, input int n);
        int bad, pbad, left;
        int cnt [256];
        logic [7:0] m;
        bad = 0; pbad = 0; left = 0;
        for (int a = 0; a < 256; a++) cnt[a] = 0;
        for (int a = 0; a < n; a++) begin
            case (sel)
                0:       m = mem0[a];
                1:       m = mem1[a];
                default: m = mem2[a[3:0]];
            endcase
            if (m !== 8'(mimg[a])) bad++;
            if (!$isunknown(m)) cnt[m]++;
        end
        for (int a = 0; a < n; a++) if (cnt[a] != 1) pbad++;
        case (sel)
            0:       left = sb0.size();
            1:       left = sb1.size();
            default: left = sb2.size();
        endcase
        chk({nm, "_image"}, bad, 0);
        chk({nm, "_perm"}, pbad, 0);
        chk({nm, "_drain"}, left, 0);
    endtask

    initial begin
        int bad, k1, k2;
        rst_n = 1'b0; preload1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        key0 = '0; key1 = '0; key2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(a0), 0);
        chk("rst_data", 32'(d0), 0);
        chk("rst_we", 32'(we0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_fin", 32'(fin0), 0);
        @(negedge clk) begin rst_n = 1'b1; preload1 = 1'b1; end
        @(negedge clk) preload1 = 1'b0;

        // Default engine, key 00 02 49
        sel = 0; key0 = 24'h000249;
        model(256, 3, 128'(key0), 1'b1); sb0 = mq;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        run_to_finish(1793, "a", 1'b0);
        check_image("a", 256);
        for (int x = 0; x < 256; x++) imga[x] = mimg[x];

        // Swap pass only, RAM preloaded to identity
        sel = 1; key1 = 24'h000249;
        model(256, 3, 128'(key1), 1'b0); sb1 = mq;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        run_to_finish(1537, "b", 1'b1);
        check_image("b", 256);
        bad = 0;
        for (int x = 0; x < 256; x++) if (mem1[x] !== 8'(imga[x])) bad++;
        chk("b_same_as_a", bad, 0);

        // Reset in the middle of a swap write, then restart with start already high
        sel = 0; key0 = 24'($urandom);
        model(256, 3, 128'(key0), 1'b1); sb0 = mq;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("c_we_before_rst", 32'(we0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("c_rst_we", 32'(we0), 0);
        chk("c_rst_addr", 32'(a0), 0);
        chk("c_rst_data", 32'(d0), 0);
        chk("c_rst_busy", 32'(busy0), 0);
        chk("c_rst_fin", 32'(fin0), 0);
        sb0.delete();
        repeat (3) @(negedge clk);
        start0 = 1'b1; key0 = 24'($urandom);
        model(256, 3, 128'(key0), 1'b1); sb0 = mq;
        rst_n = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        run_to_finish(1793, "c", 1'b0);
        check_image("c", 256);

        // 16-entry engine, one-byte key; first key 05 then random keys
        sel = 2;
        for (int r = 0; r < 3; r++) begin
            key2 = (r == 0) ? 8'h05 : 8'($urandom);
            model(16, 1, 128'(key2), 1'b1); sb2 = mq;
            @(negedge clk) start2 = 1'b1;
            @(posedge clk); #1; start2 = 1'b0;
            run_to_finish(113, "d", 1'b0);
            check_image("d", 16);
        end

        // Start and key churn while busy; start left high for a back-to-back run
        k1 = int'($urandom_range(0, 255));
        k2 = int'($urandom_range(0, 255));
        key2 = 8'(k1);
        model(16, 1, 128'(k1), 1'b1); sb2 = mq;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        fork
            run_to_finish(113, "e", 1'b0);
            begin
                repeat (10) @(negedge clk);
                for (int t = 0; t < 6; t++) begin
                    start2 = ~start2;
                    key2   = 8'($urandom);
                    @(negedge clk);
                end
                start2 = 1'b1;
                key2   = 8'(k2);
            end
        join
        check_image("e", 16);
        model(16, 1, 128'(k2), 1'b1); sb2 = mq;
        chk("e_idle_busy", 32'(busy2), 0);
        @(posedge clk); #1; start2 = 1'b0;
        run_to_finish(113, "f", 1'b0);
        check_image("f", 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
